// File: rtl/storage_loader_if.sv
// Bus bundle between storage_loader and its environment.
//   master : the transfer controller (drives both memory ports, busy/done/words_done)
//   slave  : the CPU/BIOS side plus the two memories (drives start/config and read data)
// Signals:
//   start, direction, src_base, dst_base, length : transfer request, latched on start
//   hd_read_data, mem_read_data                   : registered read outputs of the memories
//   hd_address, hd_write_enable                   : storage drive port
//   mem_address, mem_write_enable                 : main memory port
//   write_data                                    : shared write data to both memories
//   busy, done, words_done                        : transfer status
interface storage_loader_if #(
  parameter int unsigned Dw           = 32,
  parameter int unsigned HdAddrWidth  = 14,
  parameter int unsigned MemAddrWidth = 14
);
  localparam int unsigned Aw = (HdAddrWidth > MemAddrWidth) ? HdAddrWidth : MemAddrWidth;
  localparam int unsigned Lw = HdAddrWidth + 1;

  logic                    start;
  logic                    direction;
  logic [Aw-1:0]           src_base;
  logic [Aw-1:0]           dst_base;
  logic [Lw-1:0]           length;
  logic [Dw-1:0]           hd_read_data;
  logic [Dw-1:0]           mem_read_data;
  logic [HdAddrWidth-1:0]  hd_address;
  logic                    hd_write_enable;
  logic [MemAddrWidth-1:0] mem_address;
  logic                    mem_write_enable;
  logic [Dw-1:0]           write_data;
  logic                    busy;
  logic                    done;
  logic [Lw-1:0]           words_done;

  modport master (
    input  start, direction, src_base, dst_base, length, hd_read_data, mem_read_data,
    output hd_address, hd_write_enable, mem_address, mem_write_enable, write_data,
           busy, done, words_done
  );

  modport slave (
    output start, direction, src_base, dst_base, length, hd_read_data, mem_read_data,
    input  hd_address, hd_write_enable, mem_address, mem_write_enable, write_data,
           busy, done, words_done
  );
endinterface

// File: rtl/storage_loader.sv
// Word-by-word block transfer between the storage drive and main memory.
//   direction 0 = load  (storage -> memory), 1 = store (memory -> storage).
// Each word takes three cycles: ISSUE (source address presented), CAPTURE (registered
// read data captured, destination address/strobe set up), WRITE (strobe high, write
// lands on the closing edge). All outputs are registered.
// Ports:
//   clk_i  : single clock shared with both memories
//   rst_i  : asynchronous, active-high reset
//   bus_io : storage_loader_if.master (request, both memory ports, status)
module storage_loader #(
  parameter int unsigned Dw           = 32,
  parameter int unsigned HdAddrWidth  = 14,
  parameter int unsigned MemAddrWidth = 14
) (
  input logic               clk_i,
  input logic               rst_i,
  storage_loader_if.master  bus_io
);
  localparam int unsigned Aw = (HdAddrWidth > MemAddrWidth) ? HdAddrWidth : MemAddrWidth;
  localparam int unsigned Lw = HdAddrWidth + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic [Aw-1:0]           src_base_q, src_base_d;
  logic [Aw-1:0]           dst_base_q, dst_base_d;
  logic [Lw-1:0]           len_q, len_d;
  logic [Lw-1:0]           words_done_q, words_done_d;
  logic [HdAddrWidth-1:0]  hd_addr_q, hd_addr_d;
  logic [MemAddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic                    hd_we_q, hd_we_d;
  logic                    mem_we_q, mem_we_d;
  logic [Dw-1:0]           wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [Lw-1:0] words_inc;
  logic          last_word;
  logic [Aw-1:0] src_next_addr;
  logic [Aw-1:0] dst_addr;

  assign words_inc     = words_done_q + Lw'(1);
  assign last_word     = (words_inc == len_q);
  // Addresses wrap naturally by truncation to each memory's width.
  assign src_next_addr = src_base_q + Aw'(words_inc);
  assign dst_addr      = dst_base_q + Aw'(words_done_q);

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      dir_q        <= 1'b0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      len_q        <= '0;
      words_done_q <= '0;
      hd_addr_q    <= '0;
      mem_addr_q   <= '0;
      hd_we_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      src_base_q   <= src_base_d;
      dst_base_q   <= dst_base_d;
      len_q        <= len_d;
      words_done_q <= words_done_d;
      hd_addr_q    <= hd_addr_d;
      mem_addr_q   <= mem_addr_d;
      hd_we_q      <= hd_we_d;
      mem_we_q     <= mem_we_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = (bus_io.length == '0) ? StDone : StIssue;
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StWrite;
      StWrite:   state_d = last_word ? StDone : StIssue;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and latched request
  always_comb begin
    dir_d        = dir_q;
    src_base_d   = src_base_q;
    dst_base_d   = dst_base_q;
    len_d        = len_q;
    words_done_d = words_done_q;
    hd_addr_d    = hd_addr_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    hd_we_d      = 1'b0;
    mem_we_d     = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          dir_d        = bus_io.direction;
          src_base_d   = bus_io.src_base;
          dst_base_d   = bus_io.dst_base;
          len_d        = bus_io.length;
          words_done_d = '0;
          if (bus_io.length == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            // Present the first source address so ISSUE already has it on the port.
            if (bus_io.direction) mem_addr_d = bus_io.src_base[MemAddrWidth-1:0];
            else                  hd_addr_d  = bus_io.src_base[HdAddrWidth-1:0];
          end
        end
      end
      StIssue: ;
      StCapture: begin
        wdata_d = dir_q ? bus_io.mem_read_data : bus_io.hd_read_data;
        if (dir_q) begin
          hd_addr_d = dst_addr[HdAddrWidth-1:0];
          hd_we_d   = 1'b1;
        end else begin
          mem_addr_d = dst_addr[MemAddrWidth-1:0];
          mem_we_d   = 1'b1;
        end
      end
      StWrite: begin
        words_done_d = words_inc;
        if (last_word) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (dir_q) begin
          mem_addr_d = src_next_addr[MemAddrWidth-1:0];
        end else begin
          hd_addr_d = src_next_addr[HdAddrWidth-1:0];
        end
      end
      StDone: ;
      default: ;
    endcase
  end

  assign bus_io.hd_address       = hd_addr_q;
  assign bus_io.hd_write_enable  = hd_we_q;
  assign bus_io.mem_address      = mem_addr_q;
  assign bus_io.mem_write_enable = mem_we_q;
  assign bus_io.write_data       = wdata_q;
  assign bus_io.busy             = busy_q;
  assign bus_io.done             = done_q;
  assign bus_io.words_done       = words_done_q;
endmodule

// File: tb/tb_storage_loader.sv
// Self-checking bench for storage_loader: behavioural memories on both ports, a
// whole-memory reference image updated by the copy rule, and per-cycle timing checks.
module tb_storage_loader;
  localparam int unsigned Dw    = 32;
  localparam int unsigned Hw    = 14;
  localparam int unsigned Mw    = 14;
  localparam int          Depth = 1 << 14;
  localparam int          Mask  = Depth - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  storage_loader_if #(.Dw(Dw), .HdAddrWidth(Hw), .MemAddrWidth(Mw)) bus ();

  storage_loader #(.Dw(Dw), .HdAddrWidth(Hw), .MemAddrWidth(Mw)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] hd_mem  [Depth];
  logic [31:0] mem_arr [Depth];
  logic [31:0] exp_hd  [Depth];
  logic [31:0] exp_mem [Depth];

  // Memories: registered read, synchronous write
  always @(posedge clk) begin
    bus.hd_read_data  <= hd_mem[bus.hd_address];
    bus.mem_read_data <= mem_arr[bus.mem_address];
    if (bus.hd_write_enable)  hd_mem[bus.hd_address]   <= bus.write_data;
    if (bus.mem_write_enable) mem_arr[bus.mem_address] <= bus.write_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input bit to_mem, input int a, input logic [31:0] v);
    if (to_mem) begin
      mem_arr[a] <= v;
      exp_mem[a] = v;
    end else begin
      hd_mem[a] <= v;
      exp_hd[a] = v;
    end
  endtask

  task automatic img_check(input string tag);
    int nm = 0;
    for (int i = 0; i < Depth; i++) begin
      if (hd_mem[i] !== exp_hd[i]) nm++;
      if (mem_arr[i] !== exp_mem[i]) nm++;
    end
    check_eq({tag, ".image"}, 64'(nm), 64'(0));
  endtask

  // One transfer: model update, start pulse at E0, then per-cycle sampling at negedges.
  task automatic run_xfer(input string tag, input bit dir, input int src, input int dst,
                          input int len, input bit poke);
    int limit = 3 * len + 6;
    int done_cyc = 0;
    int n_done = 0;
    int bad_busy = 0;
    int bad_we = 0;
    int wrong_we = 0;
    int wd_at_done = -1;
    bit exp_busy, exp_we, dwe, owe;
    for (int i = 0; i < len; i++) begin
      if (dir) exp_hd[(dst + i) & Mask] = exp_mem[(src + i) & Mask];
      else     exp_mem[(dst + i) & Mask] = exp_hd[(src + i) & Mask];
    end
    @(negedge clk);
    bus.direction = dir;
    bus.src_base  = 14'(src);
    bus.dst_base  = 14'(dst);
    bus.length    = 15'(len);
    bus.start     = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      exp_busy = (k <= 3 * len);
      exp_we   = ((k % 3) == 0) && (k <= 3 * len);
      dwe = dir ? bus.hd_write_enable : bus.mem_write_enable;
      owe = dir ? bus.mem_write_enable : bus.hd_write_enable;
      if (bus.busy !== exp_busy) bad_busy++;
      if (dwe != exp_we) bad_we++;
      if (owe) wrong_we++;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc   = k;
          wd_at_done = int'(bus.words_done);
        end
      end
      if (k == 1) bus.start = 1'b0;
      if (poke && k == 4) begin
        bus.start     = 1'b1;
        bus.direction = ~dir;
        bus.src_base  = 14'($urandom);
        bus.dst_base  = 14'($urandom);
        bus.length    = 15'($urandom_range(1, 50));
      end
      if (poke && k == 5) bus.start = 1'b0;
    end
    check_eq({tag, ".done_cycle"}, 64'(done_cyc), 64'(3 * len + 1));
    check_eq({tag, ".done_count"}, 64'(n_done), 64'(1));
    check_eq({tag, ".busy_bad"}, 64'(bad_busy), 64'(0));
    check_eq({tag, ".we_bad"}, 64'(bad_we), 64'(0));
    check_eq({tag, ".wrong_port_we"}, 64'(wrong_we), 64'(0));
    check_eq({tag, ".words_done"}, 64'(wd_at_done), 64'(len));
    img_check(tag);
  endtask

  initial begin
    int dir, src, dst, len;
    bus.start     = 1'b0;
    bus.direction = 1'b0;
    bus.src_base  = '0;
    bus.dst_base  = '0;
    bus.length    = '0;
    for (int i = 0; i < Depth; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      hd_mem[i]  <= a;
      exp_hd[i]  = a;
      mem_arr[i] <= b;
      exp_mem[i] = b;
    end

    // Reset state
    @(negedge clk);
    check_eq("rst.busy", 64'(bus.busy), 64'(0));
    check_eq("rst.done", 64'(bus.done), 64'(0));
    check_eq("rst.hd_we", 64'(bus.hd_write_enable), 64'(0));
    check_eq("rst.mem_we", 64'(bus.mem_write_enable), 64'(0));
    check_eq("rst.hd_addr", 64'(bus.hd_address), 64'(0));
    check_eq("rst.mem_addr", 64'(bus.mem_address), 64'(0));
    check_eq("rst.wdata", 64'(bus.write_data), 64'(0));
    check_eq("rst.words_done", 64'(bus.words_done), 64'(0));
    rst = 1'b0;

    // Load 4 words
    set_word(1'b0, 'h10, 32'hAAAA_0001);
    set_word(1'b0, 'h11, 32'hBBBB_0002);
    set_word(1'b0, 'h12, 32'hCCCC_0003);
    set_word(1'b0, 'h13, 32'hDDDD_0004);
    run_xfer("load4", 1'b0, 'h10, 'h200, 4, 1'b0);
    check_eq("load4.first", 64'(mem_arr['h200]), 64'(32'hAAAA_0001));
    check_eq("load4.last", 64'(mem_arr['h203]), 64'(32'hDDDD_0004));

    // Store 2 words with destination wrap
    set_word(1'b1, 'h5, 32'hDEAD_BEEF);
    set_word(1'b1, 'h6, 32'h1234_5678);
    run_xfer("store_wrap", 1'b1, 'h5, 'h3FFF, 2, 1'b0);
    check_eq("store_wrap.top", 64'(hd_mem['h3FFF]), 64'(32'hDEAD_BEEF));
    check_eq("store_wrap.zero", 64'(hd_mem[0]), 64'(32'h1234_5678));

    // Zero length
    run_xfer("len0", 1'b0, 'h40, 'h80, 0, 1'b0);

    // Start and input changes while busy are ignored
    run_xfer("poke", 1'b0, 'h1000, 'h2000, 6, 1'b1);

    // Reset during CAPTURE of word 2 of a 4-word load
    @(negedge clk);
    bus.direction = 1'b0;
    bus.src_base  = 14'h0100;
    bus.dst_base  = 14'h0300;
    bus.length    = 15'd4;
    bus.start     = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_eq("abort.busy", 64'(bus.busy), 64'(0));
    check_eq("abort.done", 64'(bus.done), 64'(0));
    check_eq("abort.mem_we", 64'(bus.mem_write_enable), 64'(0));
    check_eq("abort.mem_addr", 64'(bus.mem_address), 64'(0));
    check_eq("abort.hd_addr", 64'(bus.hd_address), 64'(0));
    check_eq("abort.wdata", 64'(bus.write_data), 64'(0));
    check_eq("abort.words_done", 64'(bus.words_done), 64'(0));
    exp_mem['h300] = exp_hd['h100];
    @(negedge clk);
    rst = 1'b0;
    img_check("abort");
    run_xfer("after_abort", 1'b0, 'h100, 'h300, 4, 1'b0);

    // Start held high: a new zero-length transfer launches right after DONE
    @(negedge clk);
    bus.length = '0;
    bus.start  = 1'b1;
    @(negedge clk);
    check_eq("b2b.done1", 64'(bus.done), 64'(1));
    @(negedge clk);
    check_eq("b2b.idle", 64'(bus.done), 64'(0));
    @(negedge clk);
    check_eq("b2b.done2", 64'(bus.done), 64'(1));
    check_eq("b2b.busy", 64'(bus.busy), 64'(0));
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b.quiet", 64'(bus.done), 64'(0));
    img_check("b2b");

    // Randomized transfers, some with busy-time pokes
    for (int t = 0; t < 10; t++) begin
      dir = int'($urandom_range(0, 1));
      src = int'($urandom_range(0, Mask));
      dst = (t < 3) ? int'($urandom_range(Mask - 8, Mask)) : int'($urandom_range(0, Mask));
      len = int'($urandom_range(1, 40));
      run_xfer($sformatf("rnd%0d", t), dir[0], src, dst, len, (t % 3) == 1);
    end

    // Full-length load
    run_xfer("full", 1'b0, 'h1234, 'h2222, Depth, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/storage_loader.md
# storage_loader

Word-by-word block-transfer controller that drives the synchronous storage drive (program/data store) and main data memory. It either copies a run of words from storage into main memory (load, used to bring a program in from storage) or from main memory back to storage (store). It is the initiator side of both memories' single-cycle-registered-read, synchronous-write port, and sits next to the memory unit, started by the CPU/BIOS path.

## Interface
- DW, 32, word width of both memories
- HD_ADDR_WIDTH, 14, storage address width
- MEM_ADDR_WIDTH, 14, main memory address width
- clock  in  1  single clock; both memories' read and write clocks are tied to it
- reset  in  1  asynchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- direction  in  1  0 = load (storage→memory), 1 = store (memory→storage); latched on start
- src_base  in  max(HD,MEM)_ADDR_WIDTH  first source word address; latched on start
- dst_base  in  max(HD,MEM)_ADDR_WIDTH  first destination word address; latched on start
- length  in  HD_ADDR_WIDTH+1  word count, 0..2^HD_ADDR_WIDTH; latched on start
- hd_read_data  in  DW  storage registered read output
- mem_read_data  in  DW  memory registered read output
- hd_address  out  HD_ADDR_WIDTH  storage address (read or write)
- hd_write_enable  out  1  storage write strobe
- mem_address  out  MEM_ADDR_WIDTH  memory address (read or write)
- mem_write_enable  out  1  memory write strobe
- write_data  out  DW  data to both memories' write inputs
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- words_done  out  HD_ADDR_WIDTH+1  words written in current/last transfer

## Operation
- States: IDLE, ISSUE, CAPTURE, WRITE, DONE. All outputs registered.
- IDLE: start=1 latches direction, bases, length; clears words_done; length=0 → DONE, else → ISSUE with busy=1 and source address = src_base (truncated to source width).
- ISSUE → CAPTURE unconditionally (source memory registers the word this edge).
- CAPTURE: write_data ← selected source read data; destination address ← dst_base + words_done; destination write enable ← 1; → WRITE.
- WRITE: destination write occurs on this cycle's ending edge; write enable ← 0; words_done ← words_done+1; if new words_done = length → DONE, else → ISSUE with source address = src_base + new words_done.
- DONE: done=1, busy=0 for exactly one cycle; → IDLE.
- Address arithmetic modulo 2^width of the respective memory (wrap, no error). Non-destination address port still driven but its write enable stays 0; in load hd_write_enable is never 1, in store mem_write_enable is never 1.
- start while not IDLE ignored; base/length/direction changes after latch have no effect.
- Overlapping src/dst ranges in the same memory are not possible (different memories); no hazard handling.

## Timing
- Reset (async, immediate): state IDLE; busy, done, both write enables 0; hd_address, mem_address, write_data, words_done all 0. Reset mid-transfer aborts with no further write; a write whose enable was high is dropped if reset asserts before the edge.
- Cycle numbering: start sampled at edge E0; cycle k follows edge Ek-1... cycle 1 follows E0.
- Per word 3 cycles (ISSUE, CAPTURE, WRITE); write enable high only during WRITE cycle.
- N>0 words: busy high cycles 1..3N; done high cycle 3N+1; busy low in cycle 3N+1; new start accepted from cycle 3N+2.
- length=0: done high cycle 1, busy never high, no write.
- Back-to-back: start held high continuously launches a new transfer in the cycle after DONE.

## Test plan
- Load 4 words, src_base=0x10, dst_base=0x200, storage[0x10..0x13]=A,B,C,D → memory[0x200..0x203]=A..D, mem_write_enable high exactly in cycles 3,6,9,12, done in cycle 13, words_done=4, hd_write_enable never 1.
- Store 2 words, memory[0x5]=0xDEADBEEF,[0x6]=0x12345678, dst_base=0x3FFF → storage[0x3FFF]=0xDEADBEEF, storage[0x0000]=0x12345678 (wrap), done cycle 7.
- length=0 → done cycle 1, busy 0 throughout, no write enable.
- start pulsed again during busy with different bases → ignored; original transfer completes unchanged.
- reset asserted in CAPTURE of word 2 of a 4-word load → outputs 0 immediately, only word 1 written, next start runs normally.
- Full length 2^14 load → 16384 writes, words_done=16384, done cycle 49153.
